// File: rtl/usr_pkg.sv
// Shared types for the universal shift register sequencer: operation codes and
// sequencer states.
package usr_pkg;

  typedef logic [2:0] mode_t;

  localparam mode_t HOLD = 3'd0;
  localparam mode_t SHR  = 3'd1;
  localparam mode_t SHL  = 3'd2;
  localparam mode_t LOAD = 3'd3;
  localparam mode_t ROR  = 3'd4;
  localparam mode_t ROL  = 3'd5;
  localparam mode_t ASR  = 3'd6;
  localparam mode_t CLR  = 3'd7;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/usr_step.sv
// One combinational step of the universal shift register: computes next_q
// from the current contents, the operation code and live serial/parallel inputs.
module usr_step
  import usr_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  mode_t            mode,
  input  logic [WIDTH-1:0] pload,
  input  logic             ser_msb_in,
  input  logic             ser_lsb_in,
  output logic [WIDTH-1:0] next_q
);

  always_comb begin
    next_q = q;
    case (mode)
      HOLD: next_q = q;
      SHR:  next_q = {ser_msb_in, q[WIDTH-1:1]};
      SHL:  next_q = {q[WIDTH-2:0], ser_lsb_in};
      LOAD: next_q = pload;
      ROR:  next_q = {q[0], q[WIDTH-1:1]};
      ROL:  next_q = {q[WIDTH-2:0], q[WIDTH-1]};
      ASR:  next_q = {q[WIDTH-1], q[WIDTH-1:1]};
      CLR:  next_q = '0;
      default: next_q = q;
    endcase
  end

endmodule

// File: rtl/usr_seq.sv
// Parametrised universal shift register with a multi-step sequencer: in IDLE
// the mode is applied every edge; a start pulse replays a latched op N times.
module usr_seq
  import usr_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] pload,
  input  logic             ser_msb_in,
  input  logic             ser_lsb_in,
  input  logic             start,
  input  logic [AW-1:0]    amount,
  output logic [WIDTH-1:0] q,
  output logic             ser_msb_out,
  output logic             ser_lsb_out,
  output logic             busy,
  output logic             done
);

  state_t           state_q, state_d;
  mode_t            op_q, op_d;
  logic [AW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  mode_t            step_mode;
  logic [WIDTH-1:0] step_q;

  // The single step datapath is shared: live mode in IDLE, latched op in RUN.
  assign step_mode = (state_q == RUN) ? op_q : mode_t'(mode);

  usr_step #(.WIDTH(WIDTH)) u_step (
    .q          (q_q),
    .mode       (step_mode),
    .pload      (pload),
    .ser_msb_in (ser_msb_in),
    .ser_lsb_in (ser_lsb_in),
    .next_q     (step_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= HOLD;
      count_q <= '0;
      q_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      count_q <= count_d;
      q_q     <= q_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    count_d = count_q;
    q_d     = q_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          // Launch edge only latches the op and count; q is untouched here.
          op_d    = mode_t'(mode);
          count_d = amount;
          if (amount != '0) begin
            state_d = RUN;
          end else begin
            done_d = 1'b1;
          end
        end else begin
          q_d = step_q;
        end
      end
      RUN: begin
        q_d     = step_q;
        count_d = count_q - AW'(1);
        if (count_q == AW'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
  end

  assign q           = q_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign ser_msb_out = q_q[WIDTH-1];
  assign ser_lsb_out = q_q[0];

endmodule

// File: tb/tb_usr_seq.sv
// Directed and randomized checks of usr_seq (WIDTH=8) against an arithmetic
// reference model of each operation.
module tb_usr_seq;
  import usr_pkg::*;

  localparam int unsigned W  = 8;
  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [2:0]    mode;
  logic [W-1:0]  pload;
  logic          ser_msb_in;
  logic          ser_lsb_in;
  logic          start;
  logic [AW-1:0] amount;
  logic [W-1:0]  q;
  logic          ser_msb_out;
  logic          ser_lsb_out;
  logic          busy;
  logic          done;

  int n_pass  = 0;
  int n_total = 0;
  logic [W-1:0] mq;

  usr_seq #(.WIDTH(W), .AW(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mode        (mode),
    .pload       (pload),
    .ser_msb_in  (ser_msb_in),
    .ser_lsb_in  (ser_lsb_in),
    .start       (start),
    .amount      (amount),
    .q           (q),
    .ser_msb_out (ser_msb_out),
    .ser_lsb_out (ser_lsb_out),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Reference: value of the register after one operation, by plain arithmetic.
  function automatic logic [W-1:0] model(input logic [W-1:0] cur, input logic [2:0] m,
                                         input logic [W-1:0] pl, input logic sm, input logic sl);
    int v, mask, top;
    v    = int'(cur);
    mask = (1 << W) - 1;
    top  = 1 << (W - 1);
    case (m)
      3'd1:    v = (v >> 1) + (sm ? top : 0);
      3'd2:    v = ((v * 2) & mask) + (sl ? 1 : 0);
      3'd3:    v = int'(pl);
      3'd4:    v = (v >> 1) + ((v % 2) * top);
      3'd5:    v = ((v * 2) & mask) + (v / top);
      3'd6:    v = (v >> 1) + (v & top);
      3'd7:    v = 0;
      default: v = v;
    endcase
    return W'(v & mask);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic idle_step(input logic [2:0] m, input logic [W-1:0] pl, input logic sm, input logic sl);
    mode = m; pload = pl; ser_msb_in = sm; ser_lsb_in = sl; start = 1'b0;
    @(negedge clk);
    mq = model(mq, m, pl, sm, sl);
    chk("idle_q", 32'(q), 32'(mq));
  endtask

  // Launches a sequence at the current negedge; returns at the negedge of the done cycle.
  task automatic run_seq(input logic [2:0] m, input int n, input logic [W-1:0] pl,
                         input logic sm, input logic sl, input bit lock);
    mode = m; amount = AW'(n); pload = pl; ser_msb_in = sm; ser_lsb_in = sl; start = 1'b1;
    @(negedge clk);
    start = 1'b0; mode = HOLD;
    chk("e0_q", 32'(q), 32'(mq));
    if (n == 0) begin
      chk("e0_busy_zero_amt", 32'(busy), 32'd0);
      chk("e0_done_zero_amt", 32'(done), 32'd1);
      return;
    end
    chk("e0_busy", 32'(busy), 32'd1);
    chk("e0_done", 32'(done), 32'd0);
    for (int k = 1; k <= n; k++) begin
      if (lock && k == 2) begin
        start = 1'b1; mode = CLR;
      end
      @(negedge clk);
      start = 1'b0; mode = HOLD;
      mq = model(mq, m, pl, sm, sl);
      chk("step_q", 32'(q), 32'(mq));
      if (k < n) begin
        chk("run_busy", 32'(busy), 32'd1);
        chk("run_done", 32'(done), 32'd0);
      end
    end
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_done", 32'(done), 32'd1);
    chk("ser_msb_out", 32'(ser_msb_out), 32'(mq[W-1]));
    chk("ser_lsb_out", 32'(ser_lsb_out), 32'(mq[0]));
  endtask

  initial begin
    logic [2:0] rm;
    int         rn;
    rst_n = 1'b0; mode = HOLD; pload = '0; ser_msb_in = 1'b0; ser_lsb_in = 1'b0;
    start = 1'b0; amount = '0; mq = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_q", 32'(q), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);

    // 1. Mid-cycle asynchronous reset, then single-step ops
    idle_step(LOAD, 8'h5A, 1'b0, 1'b0);
    mode = HOLD;
    #3 rst_n = 1'b0;
    #1 chk("async_rst_q", 32'(q), 32'd0);
    @(negedge clk); rst_n = 1'b1; mq = '0;
    idle_step(LOAD, 8'hA5, 1'b0, 1'b0);
    chk("load_a5", 32'(q), 32'hA5);
    idle_step(SHR, 8'h00, 1'b1, 1'b0);
    chk("shr_d2", 32'(q), 32'hD2);
    idle_step(SHL, 8'h00, 1'b0, 1'b1);
    chk("shl_a5", 32'(q), 32'hA5);
    repeat (3) idle_step(HOLD, 8'hFF, 1'b1, 1'b1);
    chk("hold_a5", 32'(q), 32'hA5);

    // 2. Sequenced rotate
    run_seq(ROL, 3, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("rol3_2d", 32'(q), 32'h2D);
    idle_step(HOLD, 8'h00, 1'b0, 1'b0);
    chk("rol3_done_drop", 32'(done), 32'd0);

    // 3. Arithmetic shift
    idle_step(LOAD, 8'h90, 1'b0, 1'b0);
    run_seq(ASR, 4, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("asr4_f9", 32'(q), 32'hF9);
    chk("asr4_msb_out", 32'(ser_msb_out), 32'd1);
    chk("asr4_lsb_out", 32'(ser_lsb_out), 32'd1);
    idle_step(HOLD, 8'h00, 1'b0, 1'b0);
    chk("asr4_single_done", 32'(done), 32'd0);

    // 4. Busy lockout, then start accepted in the done cycle
    idle_step(LOAD, 8'h81, 1'b0, 1'b0);
    run_seq(ROR, 5, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("ror5_not_cleared", 32'(q), 32'h0C);
    run_seq(SHL, 1, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("b2b_shl", 32'(q), 32'h19);
    idle_step(HOLD, 8'h00, 1'b0, 1'b0);
    chk("b2b_done_drop", 32'(done), 32'd0);

    // 5. Reset mid-sequence abandons the run
    mode = SHR; amount = AW'(6); ser_msb_in = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0; mode = HOLD;
    repeat (2) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1 chk("midseq_rst_q", 32'(q), 32'd0);
    chk("midseq_rst_busy", 32'(busy), 32'd0);
    @(negedge clk); rst_n = 1'b1; mq = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_done", 32'(done), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);
    end
    chk("post_rst_q", 32'(q), 32'd0);

    // 6. Edge amounts
    idle_step(LOAD, 8'h3C, 1'b0, 1'b0);
    run_seq(ROL, 0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("amt0_q", 32'(q), 32'h3C);
    idle_step(HOLD, 8'h00, 1'b0, 1'b0);
    chk("amt0_done_drop", 32'(done), 32'd0);
    run_seq(ROL, 8, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("rol8_3c", 32'(q), 32'h3C);
    run_seq(SHL, 9, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("shl9_00", 32'(q), 32'h00);
    idle_step(HOLD, 8'h00, 1'b0, 1'b0);

    // Randomized sequences and single steps against the model
    for (int t = 0; t < 40; t++) begin
      idle_step(LOAD, W'($urandom), 1'b0, 1'b0);
      rm = 3'($urandom_range(0, 7));
      rn = $urandom_range(0, 11);
      if (t % 4 == 3) begin
        idle_step(rm, W'($urandom), 1'($urandom), 1'($urandom));
      end else begin
        run_seq(rm, rn, W'($urandom), 1'($urandom), 1'($urandom), rn >= 2 && (t % 3 == 0));
        idle_step(HOLD, 8'h00, 1'b0, 1'b0);
        chk("rand_done_drop", 32'(done), 32'd0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/usr_seq.md
Name: usr_seq

Overview:
- Parametrised successor to the 8-bit universal shift register.
- Generalised to WIDTH bits, with an 8-op mode set that adds rotate, arithmetic shift and clear.
- Adds a multi-step sequencer: one start pulse runs N single-bit steps, reported through busy/done.
- Serialiser/deserialiser building block for datapath and serial-link blocks.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- AW, $clog2(WIDTH+1), width of the amount port.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock; asynchronous assert, active-low.
- mode  in  3  operation select (codes below).
- pload  in  WIDTH  parallel load data.
- ser_msb_in  in  1  serial bit entering at MSB on SHR.
- ser_lsb_in  in  1  serial bit entering at LSB on SHL.
- start  in  1  launch multi-step sequence (IDLE only).
- amount  in  AW  number of steps for a sequence.
- q  out  WIDTH  register contents.
- ser_msb_out  out  1  q[WIDTH-1] (combinational from q).
- ser_lsb_out  out  1  q[0] (combinational from q).
- busy  out  1  sequence in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Mode codes:
  - 000 HOLD.
  - 001 SHR: q <= {ser_msb_in, q[W-1:1]}.
  - 010 SHL: q <= {q[W-2:0], ser_lsb_in}.
  - 011 LOAD: q <= pload.
  - 100 ROR.
  - 101 ROL.
  - 110 ASR: q <= {q[W-1], q[W-1:1]}.
  - 111 CLR: q <= 0.
- Reset (rst_n low, asynchronous): q=0, busy=0, done=0, state=IDLE, count=0. Takes effect immediately, including mid-sequence. Sequence is abandoned; no done.
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
- IDLE, start=0: mode is applied as one step at every edge (single-step, as in the 8-bit block). done=0.
- IDLE, start=1 at edge E0:
  - mode latched to op_r, amount latched to count.
  - q is NOT modified at E0.
  - amount!=0: go to RUN.
  - amount==0: stay IDLE, done=1 for the cycle after E0.
- RUN:
  - At each edge, apply op_r once and decrement count.
  - At the edge where count goes 1->0: return to IDLE, done=1 for exactly the following cycle.
  - For amount=N, steps occur at edges E1..EN; busy is high from E0 to EN; done is high EN to EN+1.
- Input sampling:
  - Serial inputs and pload are sampled live at each step edge.
  - A LOAD sequence of N steps reloads pload each step.
  - HOLD and CLR sequences are legal and simply take N cycles.
- start/mode while busy are ignored; no queueing.
- start in the done cycle is accepted (state is IDLE).
- amount > WIDTH is legal: steps are performed literally. ROR/ROL wrap; SHR/SHL/ASR saturate naturally to fill bits.
- done never coincides with busy.
- ser_msb_out/ser_lsb_out track q with no extra latency.

Decomposition:
- Shared package usr_pkg: 3-bit mode typedef with named localparams (HOLD..CLR), and state typedef {IDLE, RUN}.
- Sub-module usr_step (purely combinational):
  - Inputs: q, mode, pload, ser_msb_in, ser_lsb_in.
  - Output: next_q.
  - Instanced once; the top selects mode (IDLE) or op_r (RUN).

Test Plan (WIDTH=8):
1. Reset and single-step: pulse rst_n low mid-cycle -> q=00 immediately. LOAD pload=A5 -> q=A5 next edge. SHR with ser_msb_in=1 -> q=D2. SHL with ser_lsb_in=1 -> q=A5. HOLD 3 cycles -> q=A5.
2. Sequenced rotate: q=A5, start ROL amount=3 -> q stays A5 at E0, then 4B, 96, 2D at E1..E3. busy high E0-E3. done high one cycle after E3, busy=0 then.
3. Arithmetic shift: q=90, start ASR amount=4 -> q=F9. done pulses once. ser_msb_out=1, ser_lsb_out=1.
4. Busy lockout and back-to-back: during ROR amount=5, pulse start with mode=CLR -> ignored, q ends rotated. start issued in the done cycle with SHL amount=1 -> accepted, one more done.
5. Reset mid-operation: start SHR amount=6, assert rst_n low after E2 -> q=00, busy=0 at once. No done after release.
6. Edge amounts: amount=0 with ROL -> q unchanged, busy never high, done one cycle after E0. ROL amount=8 on 3C -> q=3C. SHL amount=9, ser_lsb_in=0 -> q=00.
